// File: rtl/ysyx_25040111_lsu_axi.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_lsu_axi
//   Parametrised load/store unit for the ysyx core. Accepts one memory request
//   at a time, sends it either to a small local device window (CLINT-class)
//   or out through an AXI4 master port, and returns a one-cycle response
//   carrying aligned, sign/zero-extended load data plus an error code.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_*                 request from EXU/WBU (valid/ready, wen, sign, size,
//                         byte address, LSB-justified store data)
//   resp_*                single-cycle response pulse (data, err: 00 ok,
//                         01 misaligned/illegal size, 10 bus error)
//   io_master_aw/w/b      AXI4 write address / data / response channels
//   io_master_ar/r        AXI4 read address / data channels
//   loc_*                 local device request and response ports
// ---------------------------------------------------------------------------
module ysyx_25040111_lsu_axi #(
  parameter int          DATA_W   = 32,
  parameter int          ID_W     = 4,
  parameter int          AXI_ID   = 0,
  parameter logic [31:0] LOC_BASE = 32'h0200_0048,
  parameter logic [31:0] LOC_END  = 32'h0200_004f
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic                req_sign,
  input  logic [1:0]          req_size,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,

  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,

  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [31:0]         io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,

  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,

  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid,

  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [31:0]         io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,

  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [1:0]          io_master_rresp,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic                io_master_rlast,
  input  logic [ID_W-1:0]     io_master_rid,

  output logic                loc_req_valid,
  input  logic                loc_req_ready,
  output logic                loc_wen,
  output logic [31:0]         loc_addr,
  output logic [DATA_W-1:0]   loc_wdata,
  output logic [DATA_W/8-1:0] loc_wstrb,
  input  logic                loc_resp_valid,
  input  logic [DATA_W-1:0]   loc_rdata,
  input  logic                loc_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [3:0] {
    IDLE, ERR, AR, R, AW_W, B, LOC_REQ, LOC_RSP, RESP
  } state_t;

  state_t            state;

  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              wen_q;
  logic              aw_done;
  logic              w_done;

  logic [OFF_W-1:0]  off_q;
  logic [STRB_W-1:0] strb_base;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] wdata_sh;

  logic              req_misaligned;
  logic              req_local;
  logic              aw_fire;
  logic              w_fire;

  // rlast is implied by single-beat bursts and carries no extra information.
  logic              unused_rlast;
  assign unused_rlast = io_master_rlast;

  assign req_ready = (state == IDLE);
  assign off_q     = addr_q[OFF_W-1:0];

  // Misalignment is judged on the incoming request so the FSM can branch
  // straight to ERR on the capture edge. Dword accesses need a 64-bit bus.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      2'b11:   req_misaligned = (DATA_W == 32) || (|req_addr[2:0]);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_local = (req_addr >= LOC_BASE) && (req_addr <= LOC_END);

  // Byte-enable pattern for the access width before it is moved to its lane.
  always_comb begin
    strb_base = '0;
    case (size_q)
      2'b00:   strb_base = STRB_W'(8'h01);
      2'b01:   strb_base = STRB_W'(8'h03);
      2'b10:   strb_base = STRB_W'(8'h0f);
      default: strb_base = STRB_W'(8'hff);
    endcase
  end

  assign strb_q   = strb_base << off_q;
  assign wdata_sh = wdata_q << {off_q, 3'b000};

  // Channel payloads come only from the latched request.
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = ID_W'(AXI_ID);
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = {1'b0, size_q};
  assign io_master_awburst = 2'b01;
  assign io_master_wdata   = wdata_sh;
  assign io_master_wstrb   = strb_q;
  assign io_master_wlast   = io_master_wvalid;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = ID_W'(AXI_ID);
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = {1'b0, size_q};
  assign io_master_arburst = 2'b01;
  assign loc_wen           = wen_q;
  assign loc_addr          = addr_q;
  assign loc_wdata         = wdata_sh;
  assign loc_wstrb         = strb_q;

  assign aw_fire = io_master_awvalid && io_master_awready;
  assign w_fire  = io_master_wvalid && io_master_wready;

  // Move the addressed bytes down to bit 0, then fill the upper bits with
  // either zeros or the sign bit of the access width.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    logic              fill;
    int                nbits;
    sh = raw >> {off_q, 3'b000};
    case (size_q)
      2'b00:   begin nbits = 8;      fill = sh[7];        end
      2'b01:   begin nbits = 16;     fill = sh[15];       end
      2'b10:   begin nbits = 32;     fill = sh[31];       end
      default: begin nbits = DATA_W; fill = sh[DATA_W-1]; end
    endcase
    fill = fill & sign_q;
    for (int i = 0; i < DATA_W; i++) begin
      res[i] = (i < nbits) ? sh[i] : fill;
    end
    return res;
  endfunction

  // Transaction FSM. Every handshake output is a register updated on the
  // state transition, so each channel is raised the cycle after the decision
  // that needs it and dropped on the edge where its handshake completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      addr_q            <= '0;
      wdata_q           <= '0;
      size_q            <= '0;
      sign_q            <= 1'b0;
      wen_q             <= 1'b0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      resp_err          <= 2'b00;
      io_master_awvalid <= 1'b0;
      io_master_wvalid  <= 1'b0;
      io_master_bready  <= 1'b0;
      io_master_arvalid <= 1'b0;
      io_master_rready  <= 1'b0;
      loc_req_valid     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            sign_q  <= req_sign;
            wen_q   <= req_wen;
            if (req_misaligned) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 2'b01;
              resp_rdata <= '0;
            end else if (req_local) begin
              state         <= LOC_REQ;
              loc_req_valid <= 1'b1;
            end else if (!req_wen) begin
              state             <= AR;
              io_master_arvalid <= 1'b1;
            end else begin
              state             <= AW_W;
              io_master_awvalid <= 1'b1;
              io_master_wvalid  <= 1'b1;
              aw_done           <= 1'b0;
              w_done            <= 1'b0;
            end
          end
        end

        AR: begin
          if (io_master_arready) begin
            io_master_arvalid <= 1'b0;
            io_master_rready  <= 1'b1;
            state             <= R;
          end
        end

        R: begin
          if (io_master_rvalid) begin
            io_master_rready <= 1'b0;
            resp_valid       <= 1'b1;
            state            <= RESP;
            if ((io_master_rresp != 2'b00) || (io_master_rid != ID_W'(AXI_ID))) begin
              resp_err   <= 2'b10;
              resp_rdata <= '0;
            end else begin
              resp_err   <= 2'b00;
              resp_rdata <= extend(io_master_rdata);
            end
          end
        end

        // Address and data channels finish independently; the done flags
        // remember a handshake that happened in an earlier cycle.
        AW_W: begin
          if (aw_fire) begin
            io_master_awvalid <= 1'b0;
            aw_done           <= 1'b1;
          end
          if (w_fire) begin
            io_master_wvalid <= 1'b0;
            w_done           <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            io_master_bready <= 1'b1;
            state            <= B;
          end
        end

        B: begin
          if (io_master_bvalid) begin
            io_master_bready <= 1'b0;
            resp_valid       <= 1'b1;
            resp_rdata       <= '0;
            state            <= RESP;
            if ((io_master_bresp != 2'b00) || (io_master_bid != ID_W'(AXI_ID))) begin
              resp_err <= 2'b10;
            end else begin
              resp_err <= 2'b00;
            end
          end
        end

        LOC_REQ: begin
          if (loc_req_ready) begin
            loc_req_valid <= 1'b0;
            state         <= LOC_RSP;
          end
        end

        LOC_RSP: begin
          if (loc_resp_valid) begin
            resp_valid <= 1'b1;
            state      <= RESP;
            resp_err   <= loc_err ? 2'b10 : 2'b00;
            if (loc_err || wen_q) begin
              resp_rdata <= '0;
            end else begin
              resp_rdata <= extend(loc_rdata);
            end
          end
        end

        ERR, RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
